boss_hit_ctrl: RTL

Boss hit, death and respawn controller. It drives the `boom` and `revive` inputs of the boss sprite/judge block from the VGA pixel pipeline. Per frame, it detects pixel overlap between the player-bullet layer and the boss layer, decrements boss hit points, and holds `boom` for the explosion and respawn interval. It then issues `revive` and restores full HP. Everything runs in the pixel `clk` domain; game-rate stepping uses the single-cycle `move_tick` strobe.

---
 rtl/boss_hit_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/boss_hit_ctrl.sv
// rtl/boss_hit_ctrl.sv - boss hit, death and respawn controller
//
// Purpose: per-frame overlap detection between the player-bullet layer and
// the boss layer, hit-point bookkeeping, and the explosion / dead / revive
// sequence driving the boss judge's boom and revive inputs.
//
// Optional feature: define BOSS_HIT_COOLDOWN_EN to make the boss invulnerable
// for COOLDOWN_FRAMES frames after each registered hit.
//
// Ports:
//   clk          in   pixel clock (only clock)
//   rst          in   asynchronous active-high reset
//   move_tick    in   one-clk strobe at game movement rate
//   frame_start  in   one-clk strobe at the start of each frame
//   bullet_EN    in   current pixel is a visible player bullet
//   boss_EN      in   current pixel is the visible boss
//   boom         out  explosion / dead indication
//   revive       out  respawn request
//   hp           out  remaining hit points (4 bits)
//   hit_pulse    out  one-clk pulse per registered hit
//   bullet_clear out  one-clk pulse on the first overlap pixel of a frame

module boss_hit_ctrl #(
  parameter int BOSS_HP         = 8,
  parameter int DEATH_TICKS     = 255,
  parameter int RESPAWN_TICKS   = 120,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       frame_start,
  input  logic       bullet_EN,
  input  logic       boss_EN,
  output logic       boom,
  output logic       revive,
  output logic [3:0] hp,
  output logic       hit_pulse,
  output logic       bullet_clear
);

  typedef enum logic [1:0] {ALIVE, DYING, DEAD, REVIVE} state_t;

  localparam logic [3:0] HP_FULL   = 4'(BOSS_HP);
  localparam logic [7:0] DT_LAST   = 8'(DEATH_TICKS - 1);
  localparam logic [7:0] RT_LAST   = 8'(RESPAWN_TICKS - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

  state_t     state, state_nx;
  logic       flag, flag_nx;
  logic [7:0] tick_cnt, tick_nx;
  logic [3:0] hp_nx;
  logic       hit_nx, clear_nx;
  logic       ov;
  logic [7:0] cool;

`ifdef BOSS_HIT_COOLDOWN_EN
  logic [7:0] cool_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cool <= '0;
    else     cool <= cool_nx;
  end
`else
  // No invulnerability window: the cooldown is permanently zero.
  assign cool = COOL_LOAD & 8'd0;
`endif

  // Overlap only counts while the boss is vulnerable.
  assign ov = bullet_EN && boss_EN && (state == ALIVE) && (cool == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ALIVE;
      flag         <= 1'b0;
      tick_cnt     <= '0;
      hp           <= HP_FULL;
      hit_pulse    <= 1'b0;
      bullet_clear <= 1'b0;
      boom         <= 1'b0;
      revive       <= 1'b0;
    end else begin
      state        <= state_nx;
      flag         <= flag_nx;
      tick_cnt     <= tick_nx;
      hp           <= hp_nx;
      hit_pulse    <= hit_nx;
      bullet_clear <= clear_nx;
      boom         <= (state_nx == DYING) || (state_nx == DEAD);
      revive       <= (state_nx == REVIVE);
    end
  end

  always_comb begin
    state_nx = state;
    flag_nx  = flag;
    tick_nx  = tick_cnt;
    hp_nx    = hp;
    hit_nx   = 1'b0;
    clear_nx = 1'b0;
`ifdef BOSS_HIT_COOLDOWN_EN
    cool_nx  = cool;
`endif

    if (frame_start) begin
      // An overlap on the frame_start clock belongs to the new frame, so it
      // both restarts the flag and counts as that frame's first overlap.
      flag_nx  = ov;
      clear_nx = ov;
`ifdef BOSS_HIT_COOLDOWN_EN
      if (cool != 8'd0) cool_nx = cool - 8'd1;
`endif
      if (state == ALIVE && flag) begin
        hit_nx = 1'b1;
        hp_nx  = (hp != 4'd0) ? hp - 4'd1 : 4'd0;
`ifdef BOSS_HIT_COOLDOWN_EN
        cool_nx = COOL_LOAD;
`endif
        if (hp <= 4'd1) begin
          state_nx = DYING;
          tick_nx  = '0;
        end
      end
    end else begin
      flag_nx  = flag | ov;
      clear_nx = ov && !flag;
    end

    case (state)
      DYING: if (move_tick) begin
        if (tick_cnt == DT_LAST) begin
          state_nx = DEAD;
          tick_nx  = '0;
        end else begin
          tick_nx = tick_cnt + 8'd1;
        end
      end
      DEAD: if (move_tick) begin
        if (tick_cnt == RT_LAST) begin
          state_nx = REVIVE;
          tick_nx  = '0;
        end else begin
          tick_nx = tick_cnt + 8'd1;
        end
      end
      REVIVE: if (move_tick) begin
        state_nx = ALIVE;
        hp_nx    = HP_FULL;
        flag_nx  = 1'b0;
`ifdef BOSS_HIT_COOLDOWN_EN
        cool_nx  = '0;
`endif
      end
      default: ;
    endcase
  end

endmodule
